pe_filter3x3: RTL and testbench
===============================

// Module: pe_filter3x3
// PURPOSE
//  3x3 convolution datapath for one PE, directly downstream of the PE controller.
//  Loads 9 weights using the controller's weight_in_valid/weight_addr sequence.
//  While process_enable is high, accepts one 3-pixel column per beat and slides a 3x3 window.
//  Emits one signed multiply-accumulate result per complete window through a 2-stage pipeline.
// PARAMETERS
//  DATA_W    8   pixel width, unsigned
//  WEIGHT_W  8   weight width, two's complement
//  ACC_W     20  result width, signed; must be >= DATA_W+WEIGHT_W+4
// PORTS
//  clk              in   1          clock, rising edge
//  rst              in   1          asynchronous, active-low reset
//  weight_in_valid  in   1          weight write strobe from controller
//  weight_addr      in   4          tap index 0..8 = row*3+col (row 0 top, col 0 oldest)
//  weight_data      in   WEIGHT_W   weight value for weight_addr
//  process_enable   in   1          filtering allowed (controller DONE state)
//  pix_valid        in   1          pixel column present
//  pix_row_start    in   1          qualifies pix_valid: column is first of a new row
//  pix_col          in   3*DATA_W   [DATA_W-1:0]=row 0 (top) ... [3*DATA_W-1:2*DATA_W]=row 2
//  pix_ready        out  1          = process_enable (combinational)
//  out_valid        out  1          result strobe, one cycle per window
//  out_data         out  ACC_W      signed sum of w[i]*p[i], i = 0..8
// BEHAVIOUR
//  Reset: all 9 weight regs, window regs, fill count, pipeline regs, out_valid and out_data = 0.
//  Weight load: when weight_in_valid is high, w[weight_addr] <= weight_data at the clock edge.
//   - addr 9..15: write ignored.
//   - Loading is allowed in any state. Weights persist until overwritten; nothing clears them except rst.
//  Accept = pix_valid & process_enable.
//   - On accept: col0 <= col1, col1 <= col2, col2 <= pix_col.
//   - fill <= pix_row_start ? 1 : min(fill+1, 3).
//  Issue: an accept whose updated fill == 3 launches a window into the pipeline.
//   - A row_start column never issues; the first issue is on the 3rd column of the row.
//   - One issue per accept thereafter (stride 1, no padding).
//  Pipeline latency: 2 cycles.
//   - Stage 1 (cycle after issue): 9 products registered. Each is the signed weight times the
//     zero-extended pixel, DATA_W+WEIGHT_W+1 bits.
//   - Stage 2 (cycle after stage 1): adder tree result sign-extended to ACC_W and registered into
//     out_data with out_valid = 1.
//   - Full throughput: one result per cycle with back-to-back accepts. No backpressure on the output.
//  Weight/pixel collision: stage 1 always uses the weights held before that edge's write.
//   - A weight write in the same cycle as an issue affects only later windows.
//  process_enable low: pix_ready = 0, nothing is accepted, and fill is forced to 0 at the next edge.
//   - Windows already in stages 1/2 still complete and emit out_valid.
//  out_data holds its last value while out_valid = 0.
//  Async rst mid-operation: all of the above returns to its reset values immediately and in-flight
//   results are dropped.
//  No overflow: ACC_W >= DATA_W+WEIGHT_W+4 by construction. This is checked by an elaboration-time
//   assertion.
// STRUCTURE
//  Shared package pe_pkg holds:
//   - PE_TAPS = 9 and PE_ADDR_W = 4
//   - mode codes MOD_TYPE_A/B/C = 3'b001/3'b010/3'b100
//   - controller state codes INITIALIZE/READY/DONE
//   - default DATA_W/WEIGHT_W/ACC_W
//  Sub-module pe_mac9: 9 weights and 9 pixels in, issue strobe in, 2-stage product/adder-tree
//   pipeline, out_valid/out_data out.
//  The top level keeps the weight register file, the window shift registers and the fill counter.
// TESTING
//  1. Reset, then load w[i] = i+1 for addr 0..8, then write addr 9 = 0x7F.
//     -> weights 1..9 stored, addr 9 write has no effect.
//  2. Weights all 1. Three columns {1,1,1} with row_start on the first, process_enable = 1.
//     -> exactly one out_valid with out_data = 9, 2 cycles after the 3rd accept.
//  3. Weights all -128. Five columns of 255 back to back.
//     -> 3 consecutive out_valid pulses, each out_data = -293760.
//  4. Weight write to addr 4 in the same cycle as an issuing accept.
//     -> that result uses the old w[4]; the next window uses the new value.
//  5. Drop process_enable after 2 columns, raise it, send 1 column.
//     -> pix_ready = 0 while low and no out_valid; fill restarts, so 3 new columns are needed.
//  6. Assert rst low while a result is in stage 1.
//     -> out_valid stays 0, out_data = 0, and all weights read back as 0.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared PE definitions: tap geometry, mode codes, controller states, default widths.
package pe_pkg;

    localparam int unsigned PE_TAPS     = 9;
    localparam int unsigned PE_ADDR_W   = 4;
    localparam int unsigned PE_DATA_W   = 8;
    localparam int unsigned PE_WEIGHT_W = 8;
    localparam int unsigned PE_ACC_W    = 20;

    localparam logic [2:0] MOD_TYPE_A = 3'b001;
    localparam logic [2:0] MOD_TYPE_B = 3'b010;
    localparam logic [2:0] MOD_TYPE_C = 3'b100;

    typedef enum logic [1:0] {
        INITIALIZE = 2'd0,
        READY      = 2'd1,
        DONE       = 2'd2
    } pe_ctrl_state_e;

endpackage

// File: rtl/pe_mac9.sv
// 9-tap multiply-accumulate pipeline.
//   Stage 1: on issue, register w[i] * zero-extended p[i] for all taps.
//   Stage 2: adder tree of the registered products into out_data, strobe out_valid.
// Ports: clk, rst (async active-low), issue, weights (9 packed taps),
//        pixels (9 packed taps), out_valid, out_data.
module pe_mac9
    import pe_pkg::*;
#(
    parameter int unsigned DATA_W   = PE_DATA_W,
    parameter int unsigned WEIGHT_W = PE_WEIGHT_W,
    parameter int unsigned ACC_W    = PE_ACC_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          issue,
    input  logic [PE_TAPS*WEIGHT_W-1:0]   weights,
    input  logic [PE_TAPS*DATA_W-1:0]     pixels,
    output logic                          out_valid,
    output logic [ACC_W-1:0]              out_data
);

    localparam int unsigned PROD_W = DATA_W + WEIGHT_W + 1;

    logic signed [PROD_W-1:0] w_ext  [PE_TAPS];
    logic signed [PROD_W-1:0] p_ext  [PE_TAPS];
    logic signed [PROD_W-1:0] prod_d [PE_TAPS];
    logic signed [PROD_W-1:0] prod_q [PE_TAPS];
    logic                     v1_d, v1_q;
    logic signed [ACC_W-1:0]  sum_c;
    logic                     out_valid_d, out_valid_q;
    logic [ACC_W-1:0]         out_data_d, out_data_q;

    // Stage 1: signed weight times unsigned pixel, products held between issues.
    always_comb begin
        for (int i = 0; i < int'(PE_TAPS); i++) begin
            w_ext[i]  = PROD_W'($signed(weights[i*WEIGHT_W +: WEIGHT_W]));
            p_ext[i]  = PROD_W'(pixels[i*DATA_W +: DATA_W]);
            prod_d[i] = prod_q[i];
            if (issue) begin
                prod_d[i] = w_ext[i] * p_ext[i];
            end
        end
        v1_d = issue;
    end

    // Stage 2: sign-extend and sum; out_data holds between results.
    always_comb begin
        sum_c = '0;
        for (int i = 0; i < int'(PE_TAPS); i++) begin
            sum_c = sum_c + ACC_W'(prod_q[i]);
        end
        out_valid_d = v1_q;
        out_data_d  = out_data_q;
        if (v1_q) begin
            out_data_d = sum_c;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(PE_TAPS); i++) begin
                prod_q[i] <= '0;
            end
            v1_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            for (int i = 0; i < int'(PE_TAPS); i++) begin
                prod_q[i] <= prod_d[i];
            end
            v1_q        <= v1_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: rtl/pe_filter3x3.sv
// 3x3 convolution datapath for one PE.
// Holds the 9-entry weight file, the 3-column sliding window and the fill counter,
// and launches one window per accepted column once 3 columns of the row are present.
// Ports: clk, rst (async active-low), weight_in_valid/weight_addr/weight_data (weight load),
//        process_enable, pix_valid, pix_row_start, pix_col (column input), pix_ready,
//        out_valid, out_data (signed MAC result, 2 cycles after the issuing accept).
module pe_filter3x3
    import pe_pkg::*;
#(
    parameter int unsigned DATA_W   = PE_DATA_W,
    parameter int unsigned WEIGHT_W = PE_WEIGHT_W,
    parameter int unsigned ACC_W    = PE_ACC_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  weight_in_valid,
    input  logic [PE_ADDR_W-1:0]  weight_addr,
    input  logic [WEIGHT_W-1:0]   weight_data,
    input  logic                  process_enable,
    input  logic                  pix_valid,
    input  logic                  pix_row_start,
    input  logic [3*DATA_W-1:0]   pix_col,
    output logic                  pix_ready,
    output logic                  out_valid,
    output logic [ACC_W-1:0]      out_data
);

    localparam int unsigned COL_W = 3 * DATA_W;

    if (ACC_W < DATA_W + WEIGHT_W + 4) begin : g_acc_w_check
        $error("pe_filter3x3: ACC_W too narrow for a 9-tap sum");
    end

    logic [WEIGHT_W-1:0]          w_d   [PE_TAPS];
    logic [WEIGHT_W-1:0]          w_q   [PE_TAPS];
    logic [COL_W-1:0]             col_d [3];
    logic [COL_W-1:0]             col_q [3];
    logic [1:0]                   fill_d, fill_q;
    logic                         accept_c;
    logic                         issue_c;
    logic [PE_TAPS*WEIGHT_W-1:0]  weights_flat;
    logic [PE_TAPS*DATA_W-1:0]    pixels_flat;

    assign pix_ready = process_enable;
    assign accept_c  = pix_valid & process_enable;
    assign issue_c   = accept_c & (fill_d == 2'd3);

    // Weight file; addresses 9..15 match no tap and are dropped.
    always_comb begin
        for (int i = 0; i < int'(PE_TAPS); i++) begin
            w_d[i] = w_q[i];
            if (weight_in_valid && (weight_addr == PE_ADDR_W'(i))) begin
                w_d[i] = weight_data;
            end
        end
    end

    // Window shift and fill count; disabling the PE restarts the fill.
    always_comb begin
        col_d  = col_q;
        fill_d = fill_q;
        if (!process_enable) begin
            fill_d = 2'd0;
        end else if (accept_c) begin
            col_d[0] = col_q[1];
            col_d[1] = col_q[2];
            col_d[2] = pix_col;
            if (pix_row_start) begin
                fill_d = 2'd1;
            end else if (fill_q != 2'd3) begin
                fill_d = fill_q + 2'd1;
            end
        end
    end

    // MAC sees the window including this beat's column, but the weights from before this edge.
    always_comb begin
        weights_flat = '0;
        pixels_flat  = '0;
        for (int i = 0; i < int'(PE_TAPS); i++) begin
            weights_flat[i*WEIGHT_W +: WEIGHT_W] = w_q[i];
        end
        for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 3; r++) begin
                pixels_flat[(r*3+c)*DATA_W +: DATA_W] = col_d[c][r*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(PE_TAPS); i++) begin
                w_q[i] <= '0;
            end
            for (int c = 0; c < 3; c++) begin
                col_q[c] <= '0;
            end
            fill_q <= '0;
        end else begin
            for (int i = 0; i < int'(PE_TAPS); i++) begin
                w_q[i] <= w_d[i];
            end
            for (int c = 0; c < 3; c++) begin
                col_q[c] <= col_d[c];
            end
            fill_q <= fill_d;
        end
    end

    pe_mac9 #(
        .DATA_W   (DATA_W),
        .WEIGHT_W (WEIGHT_W),
        .ACC_W    (ACC_W)
    ) u_mac9 (
        .clk       (clk),
        .rst       (rst),
        .issue     (issue_c),
        .weights   (weights_flat),
        .pixels    (pixels_flat),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

endmodule

// File: tb/tb_pe_filter3x3.sv
// Bench for pe_filter3x3: row-buffer reference model, per-cycle output compare, literal pins.
module tb_pe_filter3x3;

    logic        clk;
    logic        rst;
    logic        weight_in_valid;
    logic [3:0]  weight_addr;
    logic [7:0]  weight_data;
    logic        process_enable;
    logic        pix_valid;
    logic        pix_row_start;
    logic [23:0] pix_col;
    logic        pix_ready;
    logic        out_valid;
    logic [19:0] out_data;

    pe_filter3x3 dut (
        .clk             (clk),
        .rst             (rst),
        .weight_in_valid (weight_in_valid),
        .weight_addr     (weight_addr),
        .weight_data     (weight_data),
        .process_enable  (process_enable),
        .pix_valid       (pix_valid),
        .pix_row_start   (pix_row_start),
        .pix_col         (pix_col),
        .pix_ready       (pix_ready),
        .out_valid       (out_valid),
        .out_data        (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: columns of the current row, newest last; a window exists once 3 are held.
    int          m_w [9];
    logic [23:0] m_cols [$];
    bit          ev_v [8192];
    int          ev_d [8192];
    int          cyc = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 9; i++) m_w[i] = 0;
            m_cols.delete();
            for (int k = 0; k < 4; k++) ev_v[cyc+k] = 1'b0;
        end else begin
            cyc = cyc + 1;
            if (pix_valid && process_enable) begin
                if (pix_row_start) m_cols.delete();
                m_cols.push_back(pix_col);
                if (m_cols.size() >= 3) begin
                    int s;
                    logic [23:0] cv;
                    s = 0;
                    for (int c = 0; c < 3; c++) begin
                        cv = m_cols[m_cols.size() - 3 + c];
                        for (int r = 0; r < 3; r++) begin
                            s = s + m_w[r*3+c] * int'(cv[r*8 +: 8]);
                        end
                    end
                    ev_v[cyc+1] = 1'b1;
                    ev_d[cyc+1] = s;
                end
                if (m_cols.size() > 3) void'(m_cols.pop_front());
            end else if (!process_enable) begin
                m_cols.delete();
            end
            if (weight_in_valid && weight_addr < 4'd9) begin
                m_w[weight_addr] = int'($signed(weight_data));
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int res_q [$];
    int last_data = 0;

    task automatic check(input string name, input int got, input int exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic wr_w(input int addr, input logic [7:0] data);
        weight_in_valid = 1'b1;
        weight_addr     = 4'(addr);
        weight_data     = data;
        @(posedge clk); #2;
        weight_in_valid = 1'b0;
    endtask

    task automatic wr_all(input logic [7:0] data);
        for (int i = 0; i < 9; i++) wr_w(i, data);
    endtask

    task automatic send_col(input logic rs, input logic [23:0] col);
        pix_valid     = 1'b1;
        pix_row_start = rs;
        pix_col       = col;
        @(posedge clk); #2;
        pix_valid     = 1'b0;
        pix_row_start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #2;
        end
    endtask

    localparam logic [23:0] ONES = {3{8'd1}};
    localparam logic [23:0] FULL = {3{8'hFF}};

    initial begin
        int base;
        rst = 1'b0;
        weight_in_valid = 1'b0;
        weight_addr = '0;
        weight_data = '0;
        process_enable = 1'b0;
        pix_valid = 1'b0;
        pix_row_start = 1'b0;
        pix_col = '0;

        fork
            // Per-cycle compare against the model.
            begin
                forever begin
                    @(negedge clk);
                    check("pix_ready", int'(pix_ready), int'(process_enable));
                    if (!rst) begin
                        check("rst_out_valid", int'(out_valid), 0);
                        check("rst_out_data", int'($signed(out_data)), 0);
                        last_data = 0;
                    end else if (ev_v[cyc]) begin
                        check("out_valid", int'(out_valid), 1);
                        check("out_data", int'($signed(out_data)), ev_d[cyc]);
                        last_data = ev_d[cyc];
                    end else begin
                        check("idle_out_valid", int'(out_valid), 0);
                        check("hold_out_data", int'($signed(out_data)), last_data);
                    end
                    if (out_valid) res_q.push_back(int'($signed(out_data)));
                end
            end
            begin
                #12 rst = 1'b1;
                @(posedge clk); #2;
                check("reset_pix_ready", int'(pix_ready), 0);

                // 1: weights 1..9, addr 9 ignored; pixel p[i]=i+1 gives sum of squares 285.
                base = res_q.size();
                for (int i = 0; i < 9; i++) wr_w(i, 8'(i + 1));
                wr_w(9, 8'h7F);
                process_enable = 1'b1;
                send_col(1'b1, {8'd7, 8'd4, 8'd1});
                send_col(1'b0, {8'd8, 8'd5, 8'd2});
                send_col(1'b0, {8'd9, 8'd6, 8'd3});
                idle(4);
                check("t1_count", res_q.size() - base, 1);
                if (res_q.size() > base) check("t1_value", res_q[base], 285);

                // 2: unit weights, three unit columns.
                base = res_q.size();
                wr_all(8'd1);
                send_col(1'b1, ONES);
                send_col(1'b0, ONES);
                send_col(1'b0, ONES);
                idle(4);
                check("t2_count", res_q.size() - base, 1);
                if (res_q.size() > base) check("t2_value", res_q[base], 9);

                // 3: most negative weights, full-scale pixels, back to back.
                base = res_q.size();
                wr_all(8'h80);
                send_col(1'b1, FULL);
                for (int k = 0; k < 4; k++) send_col(1'b0, FULL);
                idle(4);
                check("t3_count", res_q.size() - base, 3);
                for (int k = 0; k < 3; k++)
                    if (res_q.size() > base + k) check("t3_value", res_q[base+k], -293760);

                // 4: weight write colliding with an issuing accept.
                base = res_q.size();
                wr_all(8'd1);
                send_col(1'b1, ONES);
                send_col(1'b0, ONES);
                weight_in_valid = 1'b1;
                weight_addr = 4'd4;
                weight_data = 8'd5;
                send_col(1'b0, ONES);
                weight_in_valid = 1'b0;
                send_col(1'b0, ONES);
                idle(4);
                check("t4_count", res_q.size() - base, 2);
                if (res_q.size() > base + 1) begin
                    check("t4_old_w", res_q[base], 9);
                    check("t4_new_w", res_q[base+1], 13);
                end

                // 5: enable dropped mid-row restarts the fill.
                wr_w(4, 8'd1);
                base = res_q.size();
                send_col(1'b1, ONES);
                send_col(1'b0, ONES);
                process_enable = 1'b0;
                pix_valid = 1'b1;
                pix_col = ONES;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("t5_ready_low", int'(pix_ready), 0);
                    @(posedge clk); #2;
                end
                pix_valid = 1'b0;
                process_enable = 1'b1;
                send_col(1'b0, ONES);
                idle(4);
                check("t5_no_out", res_q.size() - base, 0);
                send_col(1'b0, ONES);
                send_col(1'b0, ONES);
                idle(4);
                check("t5_count", res_q.size() - base, 1);
                if (res_q.size() > base) check("t5_value", res_q[base], 9);

                // 6: async reset with a window in stage 1.
                base = res_q.size();
                send_col(1'b1, ONES);
                send_col(1'b0, ONES);
                send_col(1'b0, ONES);
                rst = 1'b0;
                #1;
                check("t6_valid_rst", int'(out_valid), 0);
                check("t6_data_rst", int'($signed(out_data)), 0);
                idle(2);
                rst = 1'b1;
                idle(4);
                check("t6_dropped", res_q.size() - base, 0);
                send_col(1'b1, FULL);
                send_col(1'b0, FULL);
                send_col(1'b0, FULL);
                idle(4);
                check("t6_count", res_q.size() - base, 1);
                if (res_q.size() > base) check("t6_zero_w", res_q[base], 0);
                idle(2);
            end
        join_any
        disable fork;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
